// File: rtl/lcd_scanout.sv
// LCD scan-out: raster timing, incremental frame-buffer addressing and pixel-to-RGB conversion.
// Define LCD_SCANOUT_DOUBLE_EN for 2x scaling (320x288 active); the default build is 1:1 (160x144).
module lcd_scanout #(
  parameter int H_FRONT = 16,
  parameter int H_SYNC  = 32,
  parameter int H_BACK  = 48,
  parameter int V_FRONT = 3,
  parameter int V_SYNC  = 4,
  parameter int V_BACK  = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce_pix,
  input  logic        on,
  input  logic        isGBC,
  output logic [14:0] rd_addr,
  input  logic [14:0] rd_data,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b,
  output logic        hs,
  output logic        vs,
  output logic        hblank,
  output logic        vblank,
  output logic        de
);

`ifdef LCD_SCANOUT_DOUBLE_EN
  localparam int HA = 320;
  localparam int VA = 288;
`else
  localparam int HA = 160;
  localparam int VA = 144;
`endif

  localparam int HT = HA + H_FRONT + H_SYNC + H_BACK;
  localparam int VT = VA + V_FRONT + V_SYNC + V_BACK;
  localparam int HW = $clog2(HT);
  localparam int VW = $clog2(VT);

  localparam logic [HW-1:0] H_LAST     = HW'(HT - 1);
  localparam logic [HW-1:0] H_ACT      = HW'(HA);
  localparam logic [HW-1:0] H_ACT_LAST = HW'(HA - 1);
  localparam logic [HW-1:0] HS_START   = HW'(HA + H_FRONT);
  localparam logic [HW-1:0] HS_END     = HW'(HA + H_FRONT + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST     = VW'(VT - 1);
  localparam logic [VW-1:0] VF_START   = VW'(VA);
  localparam logic [VW-1:0] VS_START   = VW'(VA + V_FRONT);
  localparam logic [VW-1:0] VB_START   = VW'(VA + V_FRONT + V_SYNC);
  localparam logic [14:0]   LINE_WORDS = 15'd160;

  typedef enum logic [1:0] {ACTIVE, VFRONT, VSYNC, VBACK} vstate_t;

  vstate_t       state_q, state_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic [14:0]   line_base_q, line_base_d;
  logic [14:0]   rd_addr_q, rd_addr_d;
  logic [7:0]    r_q, g_q, b_q;
  logic          hs_q, vs_q, hblank_q, vblank_q, de_q;

  logic          h_wrap, v_wrap, h_act, v_act, h_act_d, v_act_d, pix_act, line_end, hs_cur;
  logic [14:0]   addr_inc;
  logic [23:0]   rgb_pix;

  function automatic logic [7:0] expand5(input logic [4:0] c);
    return {c, c[4:2]};
  endfunction

  assign h_wrap  = (hcnt_q == H_LAST);
  assign v_wrap  = h_wrap && (vcnt_q == V_LAST);
  assign hcnt_d  = h_wrap ? '0 : hcnt_q + 1'b1;
  assign vcnt_d  = h_wrap ? (v_wrap ? '0 : vcnt_q + 1'b1) : vcnt_q;
  assign h_act   = (hcnt_q < H_ACT);
  assign v_act   = (state_q == ACTIVE);
  assign h_act_d = (hcnt_d < H_ACT);
  assign v_act_d = (state_d == ACTIVE);
  assign pix_act = h_act && v_act;
  assign hs_cur  = (hcnt_q >= HS_START) && (hcnt_q <= HS_END);

  always_comb begin
    state_d = state_q;
    if (h_wrap) begin
      case (state_q)
        ACTIVE:  if (vcnt_d == VF_START) state_d = VFRONT;
        VFRONT:  if (vcnt_d == VS_START) state_d = VSYNC;
        VSYNC:   if (vcnt_d == VB_START) state_d = VBACK;
        VBACK:   if (v_wrap)             state_d = ACTIVE;
        default:                         state_d = ACTIVE;
      endcase
    end
  end

  // Base advances at the last active pixel so it is ready when the next line starts.
`ifdef LCD_SCANOUT_DOUBLE_EN
  assign line_end = v_act && (hcnt_q == H_ACT_LAST) && vcnt_q[0];
  assign addr_inc = {14'd0, ~hcnt_d[0]};
`else
  assign line_end = v_act && (hcnt_q == H_ACT_LAST);
  assign addr_inc = 15'd1;
`endif

  always_comb begin
    line_base_d = line_base_q;
    if (v_wrap)        line_base_d = '0;
    else if (line_end) line_base_d = line_base_q + LINE_WORDS;
  end

  always_comb begin
    rd_addr_d = rd_addr_q;
    if (h_act_d && v_act_d) begin
      if (hcnt_d == '0) rd_addr_d = line_base_d;
      else              rd_addr_d = rd_addr_q + addr_inc;
    end
  end

  always_comb begin
    rgb_pix = '0;
    if (!on) begin
      rgb_pix = 24'hFFFFFF;
    end else if (isGBC) begin
      rgb_pix = {expand5(rd_data[4:0]), expand5(rd_data[9:5]), expand5(rd_data[14:10])};
    end else begin
      case (rd_data[1:0])
        2'd0:    rgb_pix = 24'hFFFFFF;
        2'd1:    rgb_pix = 24'hAAAAAA;
        2'd2:    rgb_pix = 24'h555555;
        default: rgb_pix = 24'h000000;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ACTIVE;
      hcnt_q      <= '0;
      vcnt_q      <= '0;
      line_base_q <= '0;
      rd_addr_q   <= '0;
      r_q         <= '0;
      g_q         <= '0;
      b_q         <= '0;
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
      hblank_q    <= 1'b0;
      vblank_q    <= 1'b0;
      de_q        <= 1'b0;
    end else if (ce_pix) begin
      state_q     <= state_d;
      hcnt_q      <= hcnt_d;
      vcnt_q      <= vcnt_d;
      line_base_q <= line_base_d;
      rd_addr_q   <= rd_addr_d;
      r_q         <= pix_act ? rgb_pix[23:16] : 8'd0;
      g_q         <= pix_act ? rgb_pix[15:8]  : 8'd0;
      b_q         <= pix_act ? rgb_pix[7:0]   : 8'd0;
      hs_q        <= hs_cur;
      vs_q        <= (state_q == VSYNC);
      hblank_q    <= !h_act;
      vblank_q    <= !v_act;
      de_q        <= pix_act;
    end
  end

  assign rd_addr = rd_addr_q;
  assign r       = r_q;
  assign g       = g_q;
  assign b       = b_q;
  assign hs      = hs_q;
  assign vs      = vs_q;
  assign hblank  = hblank_q;
  assign vblank  = vblank_q;
  assign de      = de_q;

endmodule

// File: tb/tb_lcd_scanout.sv
// Scoreboard bench for lcd_scanout: raster-position reference model, RAM model, random colour modes.
module tb_lcd_scanout;

  localparam int HF = 2, HS = 3, HB = 3;
  localparam int VF = 2, VS = 2, VB = 2;
`ifdef LCD_SCANOUT_DOUBLE_EN
  localparam int HA = 320, VA = 288;
`else
  localparam int HA = 160, VA = 144;
`endif
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  logic        clk = 1'b0, reset = 1'b1, ce_pix = 1'b0, on = 1'b1, isGBC = 1'b1;
  logic [14:0] rd_data = '0;
  logic [14:0] rd_addr;
  logic [7:0]  r, g, b;
  logic        hs, vs, hblank, vblank, de;

  lcd_scanout #(
    .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk(clk), .reset(reset), .ce_pix(ce_pix), .on(on), .isGBC(isGBC),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .r(r), .g(g), .b(b),
    .hs(hs), .vs(vs), .hblank(hblank), .vblank(vblank), .de(de)
  );

  always #5 clk = ~clk;

  logic [14:0] mem [0:23039];
  always @(posedge clk) rd_data <= (rd_addr < 15'd23040) ? mem[rd_addr] : 15'd0;

  typedef struct packed {
    logic [23:0] rgb;
    logic [4:0]  flags;
    logic [14:0] addr;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   checks = 0, errors = 0;
  int   pos_h = 0, pos_v = 0, last_addr = 0;
  int   tick_no = 0, last_hs_tick = -1;
  logic hs_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic int src_addr(input int h, input int v);
`ifdef LCD_SCANOUT_DOUBLE_EN
    return (v / 2) * 160 + h / 2;
`else
    return v * 160 + h;
`endif
  endfunction

  function automatic logic [7:0] expand5(input int c);
    return 8'(c * 8 + c / 4);
  endfunction

  function automatic logic [23:0] model_rgb(input logic [14:0] w, input logic gbc,
                                            input logic en, input logic act);
    int lvl;
    if (!act) return 24'h0;
    if (!en) return 24'hFFFFFF;
    if (gbc) return {expand5(int'(w[4:0])), expand5(int'(w[9:5])), expand5(int'(w[14:10]))};
    lvl = 255 - 85 * int'(w[1:0]);
    return {8'(lvl), 8'(lvl), 8'(lvl)};
  endfunction

  // Issue one pixel tick from a negedge; expected output is queued before the active edge.
  task automatic tick();
    exp_t        e;
    logic        act, hs_e, vs_e;
    logic [14:0] w;
    if ($urandom_range(0, 31) == 0) isGBC = ~isGBC;
    if ($urandom_range(0, 63) == 0) on = ~on;
    act    = (pos_h < HA) && (pos_v < VA);
    w      = act ? mem[src_addr(pos_h, pos_v)] : 15'd0;
    hs_e   = (pos_h >= HA + HF) && (pos_h < HA + HF + HS);
    vs_e   = (pos_v >= VA + VF) && (pos_v < VA + VF + VS);
    e.rgb  = model_rgb(w, isGBC, on, act);
    e.flags = {hs_e, vs_e, !(pos_h < HA), !(pos_v < VA), act};
    pos_h++;
    if (pos_h == HT) begin
      pos_h = 0;
      pos_v++;
      if (pos_v == VT) pos_v = 0;
    end
    if ((pos_h < HA) && (pos_v < VA)) last_addr = src_addr(pos_h, pos_v);
    e.addr = 15'(last_addr);
    sbq.push_back(e);
    ce_pix = 1'b1;
    @(negedge clk);
    ce_pix = 1'b0;
    @(negedge clk);
    if ($urandom_range(0, 15) == 0) @(negedge clk);
  endtask

  always @(posedge clk) begin
    if (ce_pix) begin
      #1;
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard: DUT output with no expected entry (t=%0t)", $time);
      end else begin
        mon_e = sbq.pop_front();
        chk("rgb", {8'd0, r, g, b}, {8'd0, mon_e.rgb});
        chk("hs_vs_hb_vb_de", {27'd0, hs, vs, hblank, vblank, de}, {27'd0, mon_e.flags});
        chk("rd_addr", {17'd0, rd_addr}, {17'd0, mon_e.addr});
      end
      tick_no++;
      if (hs && !hs_prev) begin
        if (last_hs_tick >= 0) chk("hs_period", 32'(tick_no - last_hs_tick), 32'(HT));
        last_hs_tick = tick_no;
      end
      hs_prev = hs;
    end
  end

  initial begin
    for (int n = 0; n < 23040; n++) mem[n] = 15'($urandom);
    mem[0] = 15'h7FFF;
    mem[1] = 15'h001F;
    mem[2] = 15'h0210;
    mem[3] = 15'd0;
    mem[4] = 15'd1;
    mem[5] = 15'd2;
    mem[6] = 15'd3;

    repeat (3) @(negedge clk);
    chk("reset_rgb", {8'd0, r, g, b}, 32'd0);
    chk("reset_flags_addr", {12'd0, hs, vs, hblank, vblank, de, rd_addr}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    while (!(pos_v == 70 && pos_h == 80)) tick();
    chk("pre_reset_de", {31'd0, de}, 32'd1);

    reset = 1'b1;
    #1;
    chk("midframe_reset_rgb", {8'd0, r, g, b}, 32'd0);
    chk("midframe_reset_flags_addr", {12'd0, hs, vs, hblank, vblank, de, rd_addr}, 32'd0);
    chk("queue_empty_at_reset", 32'(sbq.size()), 32'd0);
    repeat (2) @(negedge clk);
    pos_h = 0;
    pos_v = 0;
    last_addr = 0;
    hs_prev = 1'b0;
    last_hs_tick = -1;
    reset = 1'b0;
    repeat (2) @(negedge clk);

    repeat (HT * VT + 2 * HT) tick();
    repeat (4) @(negedge clk);
    chk("queue_drained", 32'(sbq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
